// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Machine-mode trap / MRET sequencer. Owns the CSR file's single write port.
//
// Trap (exception or interrupt) sequence:
//   IDLE -> W_EPC -> W_CAUSE -> W_TVAL -> RD_STATUS -> W_STATUS -> REDIRECT
//   Writes mepc, mcause and mtval, reads mstatus, writes the updated mstatus,
//   then issues a one-cycle fetch redirect to the trap vector.
//
// MRET sequence:
//   IDLE -> RD_STATUS -> W_STATUS -> REDIRECT
//   Reads mstatus, writes the restored mstatus, then redirects fetch to mepc.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   exc_valid/intr/cause/pc/tval
//                       trap request and its payload, sampled only in IDLE
//   mret_valid          MRET retiring, sampled only in IDLE (loses to exc_valid)
//   trap_vec            live mtvec value from the CSR file
//   exception_pc        live mepc value from the CSR file
//   csr_rd_addr/data    CSR read port (address is always mstatus)
//   csr_wb/wr_addr/wr_data
//                       CSR write port; address and data are zero when idle
//   busy                pipeline stall, high whenever a sequence is in flight
//   redirect_valid/pc   one-cycle fetch redirect
//
// All outputs are decoded from the state register and the latched payload;
// request inputs never reach an output combinationally. The redirect target
// is taken from trap_vec / exception_pc while in REDIRECT so it reflects the
// CSR contents after this sequence's writes.
//
// Configuration macro:
//   TRAP_VECTORED_EN    when defined, interrupts taken with mtvec mode 2'b01
//                       jump to base + cause*4; otherwise every trap jumps to
//                       the base address and mtvec[1:0] is ignored.
// -----------------------------------------------------------------------------
module trap_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_valid,
   input  logic        exc_intr,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic [31:0] trap_vec,
   input  logic [31:0] exception_pc,
   output logic [11:0] csr_rd_addr,
   input  logic [31:0] csr_rd_data,
   output logic        csr_wb,
   output logic [11:0] csr_wr_addr,
   output logic [31:0] csr_wr_data,
   output logic        busy,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   // CSR addresses touched by the sequencer
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_W_EPC     = 3'd1,
      S_W_CAUSE   = 3'd2,
      S_W_TVAL    = 3'd3,
      S_RD_STATUS = 3'd4,
      S_W_STATUS  = 3'd5,
      S_REDIRECT  = 3'd6
   } state_t;

   // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M-mode
   function automatic logic [31:0] trap_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[7]     = s[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // mstatus on MRET: MIE <- MPIE, MPIE <- 1, MPP stays at M-mode
   function automatic logic [31:0] mret_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[3]     = s[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   state_t      state_q,  state_d;
   logic        trap_q,   trap_d;
   logic        intr_q,   intr_d;
   logic [4:0]  cause_q,  cause_d;
   logic [31:0] pc_q,     pc_d;
   logic [31:0] tval_q,   tval_d;
   logic [31:0] status_q, status_d;

   logic [31:0] tvec_base_s;
   logic [31:0] trap_tgt_s;

   assign tvec_base_s = {trap_vec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   // Vectored mode only applies to interrupts; exceptions use the base.
   assign trap_tgt_s = (intr_q && (trap_vec[1:0] == 2'b01))
                       ? (tvec_base_s + {25'd0, cause_q, 2'b00})
                       : tvec_base_s;
`else
   logic [1:0] unused_tvec_mode_s;
   assign unused_tvec_mode_s = trap_vec[1:0];
   assign trap_tgt_s         = tvec_base_s;
`endif

   // State and payload registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         trap_q   <= 1'b0;
         intr_q   <= 1'b0;
         cause_q  <= 5'd0;
         pc_q     <= 32'd0;
         tval_q   <= 32'd0;
         status_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         trap_q   <= trap_d;
         intr_q   <= intr_d;
         cause_q  <= cause_d;
         pc_q     <= pc_d;
         tval_q   <= tval_d;
         status_q <= status_d;
      end
   end

   // Next-state logic and payload capture
   always_comb begin
      state_d  = state_q;
      trap_d   = trap_q;
      intr_d   = intr_q;
      cause_d  = cause_q;
      pc_d     = pc_q;
      tval_d   = tval_q;
      status_d = status_q;
      case (state_q)
         S_IDLE: begin
            // A trap wins over a simultaneous MRET; the MRET is dropped.
            if (exc_valid) begin
               trap_d  = 1'b1;
               intr_d  = exc_intr;
               cause_d = exc_cause;
               pc_d    = exc_pc;
               tval_d  = exc_tval;
               state_d = S_W_EPC;
            end else if (mret_valid) begin
               trap_d  = 1'b0;
               state_d = S_RD_STATUS;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_W_EPC:     state_d = S_W_CAUSE;
         S_W_CAUSE:   state_d = S_W_TVAL;
         S_W_TVAL:    state_d = S_RD_STATUS;
         S_RD_STATUS: begin
            status_d = csr_rd_data;
            state_d  = S_W_STATUS;
         end
         S_W_STATUS:  state_d = S_REDIRECT;
         S_REDIRECT:  state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output decode from the current state and latched payload
   always_comb begin
      csr_rd_addr    = CSR_MSTATUS;
      csr_wb         = 1'b0;
      csr_wr_addr    = 12'h000;
      csr_wr_data    = 32'h0000_0000;
      busy           = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_W_EPC: begin
            csr_wb      = 1'b1;
            csr_wr_addr = CSR_MEPC;
            csr_wr_data = {pc_q[31:2], 2'b00};
         end
         S_W_CAUSE: begin
            csr_wb      = 1'b1;
            csr_wr_addr = CSR_MCAUSE;
            csr_wr_data = {intr_q, 26'd0, cause_q};
         end
         S_W_TVAL: begin
            csr_wb      = 1'b1;
            csr_wr_addr = CSR_MTVAL;
            csr_wr_data = tval_q;
         end
         S_RD_STATUS: begin
            csr_wb = 1'b0;
         end
         S_W_STATUS: begin
            csr_wb      = 1'b1;
            csr_wr_addr = CSR_MSTATUS;
            csr_wr_data = trap_q ? trap_status(status_q) : mret_status(status_q);
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = trap_q ? trap_tgt_s : exception_pc;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
//
// Directed bench for trap_sequencer. Expected CSR writes and redirects are
// pushed to scoreboard queues when a request is driven; a negedge monitor pops
// and compares them as the DUT produces them. Sequence latency and busy length
// are checked by the stimulus process.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_valid;
   logic        exc_intr;
   logic [4:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret_valid;
   logic [31:0] trap_vec;
   logic [31:0] exception_pc;
   logic [11:0] csr_rd_addr;
   logic [31:0] csr_rd_data;
   logic        csr_wb;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_wr_data;
   logic        busy;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic [31:0] mstatus_m;
   logic [31:0] mepc_m;
   logic [31:0] mtvec_m;

   int checks = 0;
   int errors = 0;

   logic [43:0] wq[$];
   logic [31:0] rq[$];

`ifdef TRAP_VECTORED_EN
   localparam logic [31:0] VEC_TGT = 32'h0000_021C;
`else
   localparam logic [31:0] VEC_TGT = 32'h0000_0200;
`endif

   always #5 clk = ~clk;

   assign csr_rd_data  = (csr_rd_addr == 12'h300) ? mstatus_m : 32'h0;
   assign trap_vec     = mtvec_m;
   assign exception_pc = mepc_m;

   trap_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .exc_valid      (exc_valid),
      .exc_intr       (exc_intr),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret_valid     (mret_valid),
      .trap_vec       (trap_vec),
      .exception_pc   (exception_pc),
      .csr_rd_addr    (csr_rd_addr),
      .csr_rd_data    (csr_rd_data),
      .csr_wb         (csr_wb),
      .csr_wr_addr    (csr_wr_addr),
      .csr_wr_data    (csr_wr_data),
      .busy           (busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_w(input logic [11:0] addr, input logic [31:0] data);
      wq.push_back({addr, data});
   endtask

   // Scoreboard monitor: compare every write and redirect against the queues
   always @(negedge clk) begin
      logic [43:0] e;
      logic [31:0] r;
      if (csr_wb === 1'b1) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_write: observed addr=%h data=%h expected no write",
                   csr_wr_addr, csr_wr_data);
         end else begin
            e = wq.pop_front();
            chk("wr_addr", {20'd0, csr_wr_addr}, {20'd0, e[43:32]});
            chk("wr_data", csr_wr_data, e[31:0]);
         end
      end else begin
         chk("idle_wr_addr", {20'd0, csr_wr_addr}, 32'h0);
         chk("idle_wr_data", csr_wr_data, 32'h0);
      end
      if (redirect_valid === 1'b1) begin
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_redirect: observed pc=%h expected no redirect", redirect_pc);
         end else begin
            r = rq.pop_front();
            chk("redirect_pc", redirect_pc, r);
         end
      end
   end

   // Present a request for exactly one sampling edge (mret optionally held)
   task automatic fire(input logic exc, input logic mret, input logic hold_mret,
                       input logic intr, input logic [4:0] cause,
                       input logic [31:0] pc, input logic [31:0] tval);
      @(posedge clk);
      #1;
      exc_valid  = exc;
      mret_valid = mret;
      exc_intr   = intr;
      exc_cause  = cause;
      exc_pc     = pc;
      exc_tval   = tval;
      @(posedge clk);
      #1;
      exc_valid = 1'b0;
      if (!hold_mret) mret_valid = 1'b0;
   endtask

   // Observe a bounded window after the sampling edge; cycle k is the k-th
   // negedge after it. Optional mret release and reset pulse inside the window.
   task automatic run_seq(input int mret_drop_k, input int rst_on_k, input int rst_off_k,
                          output int busy_n, output int redir_at);
      busy_n   = 0;
      redir_at = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_n++;
         if (redirect_valid === 1'b1 && redir_at == 0) redir_at = k;
         if (k == mret_drop_k) mret_valid = 1'b0;
         if (k == rst_on_k) reset = 1'b1;
         if (k == rst_off_k) reset = 1'b0;
      end
   endtask

   initial begin
      int bn;
      int ra;
      reset      = 1'b1;
      exc_valid  = 1'b0;
      exc_intr   = 1'b0;
      exc_cause  = 5'd0;
      exc_pc     = 32'h0;
      exc_tval   = 32'h0;
      mret_valid = 1'b0;
      mstatus_m  = 32'h0;
      mepc_m     = 32'h0;
      mtvec_m    = 32'h0000_0200;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_csr_wb",         {31'd0, csr_wb}, 32'h0);
      chk("rst_rd_addr",        {20'd0, csr_rd_addr}, 32'h0000_0300);
      chk("rst_busy",           {31'd0, busy}, 32'h0);
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'h0);
      chk("rst_redirect_pc",    redirect_pc, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Synchronous exception
      mstatus_m = 32'h0000_0008;
      mtvec_m   = 32'h0000_0200;
      push_w(12'h341, 32'h0000_0104);
      push_w(12'h342, 32'h0000_0002);
      push_w(12'h343, 32'hDEAD_BEEF);
      push_w(12'h300, 32'h0000_1880);
      rq.push_back(32'h0000_0200);
      fire(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0104, 32'hDEAD_BEEF);
      run_seq(0, 0, 0, bn, ra);
      chk("exc_busy_cycles", bn, 6);
      chk("exc_redirect_at", ra, 6);
      chk("exc_wq_drained",  wq.size(), 0);
      chk("exc_rq_drained",  rq.size(), 0);

      // MRET
      mstatus_m = 32'h0000_1880;
      mepc_m    = 32'h0000_0108;
      push_w(12'h300, 32'h0000_1888);
      rq.push_back(32'h0000_0108);
      fire(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      run_seq(0, 0, 0, bn, ra);
      chk("mret_busy_cycles", bn, 3);
      chk("mret_redirect_at", ra, 3);
      chk("mret_wq_drained",  wq.size(), 0);
      chk("mret_rq_drained",  rq.size(), 0);

      // Interrupt with vectored mtvec
      mstatus_m = 32'h0;
      mtvec_m   = 32'h0000_0201;
      push_w(12'h341, 32'h0000_0200);
      push_w(12'h342, 32'h8000_0007);
      push_w(12'h343, 32'h0000_0000);
      push_w(12'h300, 32'h0000_1800);
      rq.push_back(VEC_TGT);
      fire(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0200, 32'h0);
      run_seq(0, 0, 0, bn, ra);
      chk("vint_redirect_at", ra, 6);
      chk("vint_rq_drained",  rq.size(), 0);

      // Exception with the same vectored mtvec goes to the base
      push_w(12'h341, 32'h0000_0200);
      push_w(12'h342, 32'h0000_0007);
      push_w(12'h343, 32'h0000_0000);
      push_w(12'h300, 32'h0000_1800);
      rq.push_back(32'h0000_0200);
      fire(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0200, 32'h0);
      run_seq(0, 0, 0, bn, ra);
      chk("vexc_redirect_at", ra, 6);
      chk("vexc_rq_drained",  rq.size(), 0);

      // Simultaneous exc+mret, mret held through part of busy; misaligned pc
      mstatus_m = 32'h0000_0008;
      mtvec_m   = 32'h0000_0200;
      push_w(12'h341, 32'h0000_0104);
      push_w(12'h342, 32'h0000_0004);
      push_w(12'h343, 32'h0000_0011);
      push_w(12'h300, 32'h0000_1880);
      rq.push_back(32'h0000_0200);
      fire(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0106, 32'h0000_0011);
      run_seq(4, 0, 0, bn, ra);
      chk("both_busy_cycles", bn, 6);
      chk("both_redirect_at", ra, 6);
      chk("both_wq_drained",  wq.size(), 0);

      // Reset in the middle of a trap: only mepc and mcause are written
      push_w(12'h341, 32'h0000_0300);
      push_w(12'h342, 32'h0000_0005);
      fire(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_0300, 32'h0);
      run_seq(0, 2, 3, bn, ra);
      chk("rstmid_busy_cycles", bn, 2);
      chk("rstmid_no_redirect", ra, 0);
      chk("rstmid_wq_drained",  wq.size(), 0);

      // Full sequence after the aborted one
      push_w(12'h341, 32'h0000_0400);
      push_w(12'h342, 32'h0000_0002);
      push_w(12'h343, 32'h0000_0123);
      push_w(12'h300, 32'h0000_1880);
      rq.push_back(32'h0000_0200);
      fire(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0400, 32'h0000_0123);
      run_seq(0, 0, 0, bn, ra);
      chk("after_busy_cycles", bn, 6);
      chk("after_redirect_at", ra, 6);
      chk("after_wq_drained",  wq.size(), 0);
      chk("after_rq_drained",  rq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
